bus_arbiter3: RTL and testbench

//   Round-robin arbiter and sequencer for the shared 32-bit device bus. Three

---
 rtl/bus_arbiter3_pkg.sv | 35 +++
 rtl/bus_arbiter3_if.sv | 31 +++
 rtl/bus_arbiter3_rr_pick3.sv | 32 +++
 rtl/bus_arbiter3.sv | 96 +++++++++
 tb/tb_bus_arbiter3.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter3_pkg.sv
// Shared definitions for the three-way round-robin bus arbiter.
package bus_arbiter3_pkg;

    localparam int N_REQ = 3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bus mux select codes
    localparam logic [1:0] SEL_R0 = 2'd0;
    localparam logic [1:0] SEL_R1 = 2'd1;
    localparam logic [1:0] SEL_R2 = 2'd2;

    // Next requester index in circular order 0 -> 1 -> 2 -> 0.
    // An out-of-range index (3) wraps to 0 so the search never leaves 0..2.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= SEL_R2) ? SEL_R0 : idx + 2'd1;
    endfunction

    // One-hot vector for a select code
    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [1:0] s);
        logic [N_REQ-1:0] v;
        v = '0;
        case (s)
            SEL_R0:  v = 3'b001;
            SEL_R1:  v = 3'b010;
            SEL_R2:  v = 3'b100;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bus_arbiter3_if.sv
// Request/grant/bus handshake bundle between the requesters and the arbiter.
//
// Handshake: once a requester is granted, bus_valid stays high and gnt/sel stay
// stable until the rising edge on which bus_ready is sampled high (or the
// timeout expires). That edge completes the transfer; ack (and err on timeout)
// pulse for the single following cycle. req must be held until its ack.
interface bus_arbiter3_if;
    import bus_arbiter3_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       sel;
    logic             bus_valid;
    logic             bus_ready;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] err;
    logic             busy;

    // Requester/device side
    modport master (
        output req, bus_ready,
        input  gnt, sel, bus_valid, ack, err, busy
    );

    // Arbiter side
    modport slave (
        input  req, bus_ready,
        output gnt, sel, bus_valid, ack, err, busy
    );

endinterface

// File: rtl/bus_arbiter3_rr_pick3.sv
// Combinational three-way round-robin picker. Searches ptr+1, ptr+2, ptr.
module rr_pick3
    import bus_arbiter3_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       winner,
    output logic             any
);

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] cand0;
    logic [3:0] req_x;

    assign cand1 = rr_next(ptr);
    assign cand2 = rr_next(cand1);
    assign cand0 = rr_next(cand2);   // equals ptr for any legal ptr
    assign req_x = {1'b0, req};
    assign any   = |req;

    // Highest-priority pending requester in rotated order
    always_comb begin
        winner = cand0;
        if (req_x[cand1]) begin
            winner = cand1;
        end else if (req_x[cand2]) begin
            winner = cand2;
        end
    end

endmodule

// File: rtl/bus_arbiter3.sv
// Round-robin arbiter and sequencer for the shared 32-bit device bus.
// IDLE -> BUS -> DONE -> IDLE; DONE is a mandatory one-cycle turnaround
// carrying the ack/err pulse.
module bus_arbiter3
    import bus_arbiter3_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter3_if.slave  bus,
    output logic [1:0]     state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       winner;
    logic             any;

    assign state_dbg = state;

    rr_pick3 u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    // FSM, round-robin pointer, timeout counter and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            ptr           <= SEL_R2;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.sel       <= SEL_R0;
            bus.bus_valid <= 1'b0;
            bus.ack       <= '0;
            bus.err       <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.ack <= '0;
                    bus.err <= '0;
                    if (any) begin
                        state         <= ST_BUS;
                        ptr           <= winner;
                        cnt           <= '0;
                        bus.gnt       <= sel_to_onehot(winner);
                        bus.sel       <= winner;
                        bus.bus_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // Ready takes precedence over a coincident timeout
                    if (bus.bus_ready) begin
                        state         <= ST_DONE;
                        bus.ack       <= bus.gnt;
                        bus.err       <= '0;
                        bus.gnt       <= '0;
                        bus.bus_valid <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= ST_DONE;
                        bus.ack       <= bus.gnt;
                        bus.err       <= bus.gnt;
                        bus.gnt       <= '0;
                        bus.bus_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    bus.ack  <= '0;
                    bus.err  <= '0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.gnt       <= '0;
                    bus.bus_valid <= 1'b0;
                    bus.ack       <= '0;
                    bus.err       <= '0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter3.sv
// Self-checking bench for bus_arbiter3: transaction-level reference model,
// per-cycle compare, grant-order scoreboard and directed + random stimulus.
module tb_bus_arbiter3;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    bus_arbiter3_if bif ();

    bus_arbiter3 #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit cmp_en       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: who owns the bus, how long it has waited, whether we
    // are in the turnaround cycle, and who won last.
    int         m_owner = -1;
    int         m_wait  = 0;
    int         m_last  = 2;
    bit         m_turn  = 1'b0;
    logic [2:0] m_ack   = 3'b000;
    logic [2:0] m_err   = 3'b000;
    int         m_cand;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_wait = 0; m_last = 2; m_turn = 1'b0;
            m_ack = 3'b000; m_err = 3'b000;
        end else begin
            m_ack = 3'b000;
            m_err = 3'b000;
            if (m_owner >= 0) begin
                if (bif.bus_ready || m_wait == TIMEOUT - 1) begin
                    m_ack = 3'(1 << m_owner);
                    if (!bif.bus_ready) m_err = m_ack;
                    m_owner = -1;
                    m_turn  = 1'b1;
                end else begin
                    m_wait++;
                end
            end else if (m_turn) begin
                m_turn = 1'b0;
            end else if (bif.req != 3'b000) begin
                for (int k = 1; k <= 3; k++) begin
                    m_cand = (m_last + k) % 3;
                    if (m_owner < 0 && bif.req[m_cand]) begin
                        m_owner = m_cand;
                        m_last  = m_cand;
                        m_wait  = 0;
                    end
                end
            end
        end
    end

    // ---------------- compare + grant-order scoreboard ----------------
    logic [1:0] exp_q[$];
    bit         order_en   = 1'b0;
    bit         prev_valid = 1'b0;
    int         n_grants   = 0;
    logic [2:0] exp_gnt;
    logic [1:0] exp_sel;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_gnt = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            check("gnt",       32'(bif.gnt),       32'(exp_gnt));
            check("bus_valid", 32'(bif.bus_valid), 32'(m_owner >= 0));
            check("busy",      32'(bif.busy),      32'(m_owner >= 0 || m_turn));
            check("ack",       32'(bif.ack),       32'(m_ack));
            check("err",       32'(bif.err),       32'(m_err));
            if (m_owner >= 0) check("sel", 32'(bif.sel), 32'(m_owner));
            if (order_en && bif.bus_valid && !prev_valid) begin
                n_grants++;
                if (exp_q.size() == 0) begin
                    check("grant_order_extra", 32'(bif.sel), 32'hFFFF);
                end else begin
                    exp_sel = exp_q.pop_front();
                    check("grant_order", 32'(bif.sel), 32'(exp_sel));
                end
            end
            prev_valid = bif.bus_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] r, input logic rdy);
        bif.req       = r;
        bif.bus_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_valid(input string name, input int bound);
        int i;
        i = 0;
        while (!bif.bus_valid && i < bound) begin
            tick(1);
            i++;
        end
        check(name, 32'(bif.bus_valid), 32'd1);
    endtask

    int n;

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        set_in(3'b000, 1'b0);
        tick(3);
        cmp_en = 1'b1;
        // reset values
        check("rst_gnt",   32'(bif.gnt),       32'd0);
        check("rst_sel",   32'(bif.sel),       32'd0);
        check("rst_valid", 32'(bif.bus_valid), 32'd0);
        check("rst_busy",  32'(bif.busy),      32'd0);
        check("rst_ack",   32'(bif.ack),       32'd0);
        check("rst_state", 32'(state_dbg),     32'd0);
        reset = 1'b0;
        tick(1);

        // 1: single requester 0, ready on the first BUS cycle
        set_in(3'b001, 1'b0);
        wait_valid("t1_valid", 5);
        check("t1_sel", 32'(bif.sel), 32'd0);
        check("t1_gnt", 32'(bif.gnt), 32'b001);
        bif.bus_ready = 1'b1;
        tick(1);
        check("t1_ack", 32'(bif.ack), 32'b001);
        check("t1_err", 32'(bif.err), 32'b000);
        set_in(3'b000, 1'b0);
        tick(1);
        check("t1_ack_clear", 32'(bif.ack), 32'b000);
        tick(2);

        // 2: all three requesting from reset -> 0,1,2,0,1,2
        do_reset();
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        n_grants = 0;
        order_en = 1'b1;
        set_in(3'b111, 1'b1);
        n = 0;
        while (n_grants < 6 && n < 40) begin
            tick(1);
            n++;
        end
        set_in(3'b000, 1'b1);
        tick(4);
        order_en = 1'b0;
        check("t2_grants", 32'(n_grants), 32'd6);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        set_in(3'b000, 1'b0);

        // 3: timeout on requester 1
        set_in(3'b010, 1'b0);
        wait_valid("t3_valid", 5);
        n = 0;
        while (bif.bus_valid && n < 40) begin
            n++;
            tick(1);
        end
        check("t3_valid_cycles", 32'(n), 32'd16);
        check("t3_ack", 32'(bif.ack), 32'b010);
        check("t3_err", 32'(bif.err), 32'b010);
        set_in(3'b000, 1'b0);
        tick(1);
        check("t3_err_clear", 32'(bif.err), 32'b000);
        tick(2);

        // 4: ready in the last allowed cycle wins over the timeout
        set_in(3'b001, 1'b0);
        wait_valid("t4_valid", 5);
        tick(15);
        check("t4_still_valid", 32'(bif.bus_valid), 32'd1);
        bif.bus_ready = 1'b1;
        tick(1);
        check("t4_ack", 32'(bif.ack), 32'b001);
        check("t4_err", 32'(bif.err), 32'b000);
        set_in(3'b000, 1'b0);
        tick(2);

        // 5: reset mid-transaction, then priority restarts at requester 0
        set_in(3'b100, 1'b0);
        wait_valid("t5_valid", 5);
        tick(2);
        reset = 1'b1;
        #1;
        check("t5_gnt",   32'(bif.gnt),       32'd0);
        check("t5_valid", 32'(bif.bus_valid), 32'd0);
        check("t5_busy",  32'(bif.busy),      32'd0);
        check("t5_ack",   32'(bif.ack),       32'd0);
        tick(2);
        reset = 1'b0;
        set_in(3'b101, 1'b0);
        wait_valid("t5_regrant", 5);
        check("t5_sel", 32'(bif.sel), 32'd0);
        bif.bus_ready = 1'b1;
        tick(1);
        check("t5_ack_r0", 32'(bif.ack), 32'b001);
        set_in(3'b000, 1'b0);
        tick(2);

        // 6: req dropped during BUS -> still acked, no re-grant
        set_in(3'b001, 1'b0);
        wait_valid("t6_valid", 5);
        set_in(3'b000, 1'b0);
        tick(3);
        bif.bus_ready = 1'b1;
        tick(1);
        check("t6_ack", 32'(bif.ack), 32'b001);
        bif.bus_ready = 1'b0;
        tick(3);
        check("t6_no_regrant", 32'(bif.gnt),  32'd0);
        check("t6_idle",       32'(bif.busy), 32'd0);

        // random traffic against the model
        repeat (600) begin
            set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
            tick(1);
        end
        set_in(3'b000, 1'b0);
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit=%0d", 1000000);
        $fatal(1, "watchdog");
    end

endmodule
